// File: rtl/serial_subtractor.sv
// Digit-serial a - b - bin, LSB slice first, one op in flight; N=WIDTH/DIGIT RUN cycles after acceptance.
// Backpressure: result and flags hold in DONE until out_ready; in_ready is high only in IDLE.
module serial_subtractor #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    if (WIDTH < 2) begin : g_bad_width
        $error("serial_subtractor: WIDTH must be >= 2");
    end
    if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_digit
        $error("serial_subtractor: WIDTH must be a multiple of DIGIT");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic               r_borrow;
    logic               r_a_msb;
    logic               r_b_msb;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_diff;
    logic               r_bout;
    logic               r_ovf;

    logic [DIGIT:0]     w_slice;
    logic [WIDTH-1:0]   w_res_next;
    logic               w_last;

    // Extra top bit of the slice difference is the borrow into the next slice.
    assign w_slice = {1'b0, r_a_sh[DIGIT-1:0]}
                   - {1'b0, r_b_sh[DIGIT-1:0]}
                   - {{DIGIT{1'b0}}, r_borrow};

    assign w_last = (r_cnt == CNT_W'(N - 1));

    // Only the upper WIDTH-DIGIT result bits need storage; the newest slice
    // enters from the top and the full word is formed combinationally.
    if (DIGIT == WIDTH) begin : g_single_slice
        assign w_res_next = w_slice[DIGIT-1:0];
    end else begin : g_multi_slice
        logic [WIDTH-DIGIT-1:0] r_res_sh;

        assign w_res_next = {w_slice[DIGIT-1:0], r_res_sh};

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_res_sh <= '0;
            end else if (r_state == S_RUN) begin
                r_res_sh <= w_res_next[WIDTH-1:DIGIT];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_a_sh      <= '0;
            r_b_sh      <= '0;
            r_borrow    <= 1'b0;
            r_a_msb     <= 1'b0;
            r_b_msb     <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_diff      <= '0;
            r_bout      <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a_sh     <= a;
                        r_b_sh     <= b;
                        r_borrow   <= bin;
                        r_a_msb    <= a[WIDTH-1];
                        r_b_msb    <= b[WIDTH-1];
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_a_sh   <= r_a_sh >> DIGIT;
                    r_b_sh   <= r_b_sh >> DIGIT;
                    r_borrow <= w_slice[DIGIT];
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_diff      <= w_res_next;
                        r_bout      <= w_slice[DIGIT];
                        r_ovf       <= (r_a_msb != r_b_msb) &&
                                       (w_res_next[WIDTH-1] != r_a_msb);
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Returning to IDLE first keeps the output and input
                    // handshakes on separate edges.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign diff      = r_diff;
    assign bout      = r_bout;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomised bench for serial_subtractor at (WIDTH,DIGIT) = (8,1) and (8,4).
module tb_serial_subtractor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       in_valid1, in_ready1, out_valid1, out_ready1, bin1, bout1, ovf1;
    logic [7:0] a1, b1, diff1;
    logic       in_valid4, in_ready4, out_valid4, out_ready4, bin4, bout4, ovf4;
    logic [7:0] a4, b4, diff4;

    int errors = 0;
    int checks = 0;

    serial_subtractor #(.WIDTH(8), .DIGIT(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .bin(bin1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .diff(diff1), .bout(bout1), .ovf(ovf1)
    );

    serial_subtractor #(.WIDTH(8), .DIGIT(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .bin(bin4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .diff(diff4), .bout(bout4), .ovf(ovf4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One operation on the selected instance; optionally completes the output handshake.
    task automatic run_op(input bit sel, input logic [7:0] av, input logic [7:0] bv,
                          input logic bi, input bit release_out,
                          output logic [7:0] d, output logic bo, output logic ov,
                          output int lat);
        int w;
        w = 0;
        while (!(sel ? in_ready4 : in_ready1) && w < 50) begin
            @(posedge clk); #1; w++;
        end
        if (sel) begin a4 = av; b4 = bv; bin4 = bi; in_valid4 = 1'b1; end
        else     begin a1 = av; b1 = bv; bin1 = bi; in_valid1 = 1'b1; end
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        in_valid4 = 1'b0;
        lat = 0;
        while (!(sel ? out_valid4 : out_valid1) && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        d  = sel ? diff4 : diff1;
        bo = sel ? bout4 : bout1;
        ov = sel ? ovf4  : ovf1;
        if (release_out) begin
            if (sel) out_ready4 = 1'b1; else out_ready1 = 1'b1;
            @(posedge clk); #1;
            out_ready1 = 1'b0;
            out_ready4 = 1'b0;
        end
    endtask

    task automatic directed(input string tag, input bit sel, input logic [7:0] av,
                            input logic [7:0] bv, input logic bi, input logic [7:0] ed,
                            input logic eb, input logic eo, input int elat);
        logic [7:0] d;
        logic       bo, ov;
        int         lat;
        run_op(sel, av, bv, bi, 1'b1, d, bo, ov, lat);
        check({tag, "_lat"},  lat, elat);
        check({tag, "_diff"}, d,   ed);
        check({tag, "_bout"}, bo,  eb);
        check({tag, "_ovf"},  ov,  eo);
    endtask

    initial begin
        logic [7:0] d, ra, rb, ed;
        logic       bo, ov, rbi, eb, eo;
        logic [8:0] full;
        int         lat, last, nhs;
        bit         hs;

        rst_n = 1'b0;
        in_valid1 = 0; out_ready1 = 0; a1 = 0; b1 = 0; bin1 = 0;
        in_valid4 = 0; out_ready4 = 0; a4 = 0; b4 = 0; bin4 = 0;
        #12;
        check("rst_out_valid", out_valid1, 1'b0);
        check("rst_diff",      diff1,      8'h00);
        check("rst_bout_ovf",  {bout1, ovf1}, 2'b00);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", {in_ready1, in_ready4}, 2'b11);

        directed("sub_5_3",    0, 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 8);
        directed("sub_0_1",    0, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 8);
        directed("sub_bin",    0, 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0, 8);
        directed("ovf_80_01",  0, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 8);
        directed("ovf_7f_ff",  0, 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 8);
        directed("d4_5a_a5",   1, 8'h5A, 8'hA5, 1'b0, 8'hB5, 1'b1, 1'b1, 2);
        directed("d4_bin_all", 1, 8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0, 2);

        // Backpressure: result must hold while extra requests are ignored.
        run_op(0, 8'h22, 8'h11, 1'b0, 1'b0, d, bo, ov, lat);
        check("bp_first_diff", d, 8'h11);
        for (int i = 0; i < 5; i++) begin
            a1 = 8'hFF; b1 = 8'h01; in_valid1 = i[0];
            @(posedge clk); #1;
            check("bp_hold", {out_valid1, in_ready1, diff1, bout1, ovf1}, {1'b1, 1'b0, 8'h11, 1'b0, 1'b0});
        end
        in_valid1 = 1'b0;
        out_ready1 = 1'b1;
        @(posedge clk); #1;
        out_ready1 = 1'b0;
        check("bp_release", {out_valid1, in_ready1}, 2'b01);
        @(posedge clk); #1;
        check("bp_no_stale_accept", {out_valid1, in_ready1}, 2'b01);

        // Back-to-back with a stall-free consumer: one acceptance every N+2 edges.
        a1 = 8'h05; b1 = 8'h03; bin1 = 1'b0;
        in_valid1 = 1'b1; out_ready1 = 1'b1;
        last = -1; nhs = 0;
        for (int c = 0; c < 40; c++) begin
            hs = in_ready1;
            @(posedge clk); #1;
            if (hs) begin
                if (last >= 0) check("b2b_gap", c - last, 10);
                last = c;
                nhs++;
            end
        end
        in_valid1 = 1'b0; out_ready1 = 1'b0;
        check("b2b_count", nhs, 4);

        // Reset in the middle of RUN after three slices.
        a1 = 8'hAA; b1 = 8'h11; in_valid1 = 1'b1;
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #2;
        check("mid_rst_dut1", {out_valid1, diff1, bout1, ovf1}, 11'd0);
        check("mid_rst_dut4", {out_valid4, diff4, bout4, ovf4}, 11'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_in_ready", in_ready1, 1'b1);
        directed("post_rst", 0, 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 8);

        // Random operands against a plain 9-bit subtraction reference.
        for (int sel = 0; sel < 2; sel++) begin
            for (int k = 0; k < 150; k++) begin
                ra  = 8'($urandom_range(0, 255));
                rb  = 8'($urandom_range(0, 255));
                rbi = 1'($urandom_range(0, 1));
                full = {1'b0, ra} - {1'b0, rb} - {8'd0, rbi};
                ed = full[7:0];
                eb = full[8];
                eo = (ra[7] != rb[7]) && (ed[7] != ra[7]);
                run_op(sel[0], ra, rb, rbi, 1'b1, d, bo, ov, lat);
                check(sel == 0 ? "rand_d1" : "rand_d4", {lat[7:0], d, bo, ov},
                      {(sel == 0) ? 8'd8 : 8'd2, ed, eb, eo});
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
